// File: rtl/instruction_sequencer_pkg.sv
// instruction_sequencer_pkg: opcodes, FSM states and loop-stack entry shared by the sequencer files
package instruction_sequencer_pkg;
  localparam int PC_W = 10;
  localparam logic [4:0] OP_LOAD                  = 5'd15;
  localparam logic [4:0] OP_STORE                 = 5'd16;
  localparam logic [4:0] OP_START_INDEPENDENT_LOOP = 5'd17;
  localparam logic [4:0] OP_START_LOOP            = 5'd18;
  localparam logic [4:0] OP_END_LOOP              = 5'd19;
  localparam logic [4:0] OP_HALT                  = 5'd31;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ISSUE} seq_state_t;
  typedef struct packed {
    logic [PC_W-1:0] body_pc;
    logic [2:0]      remaining;
  } loop_entry_t;
  function automatic logic is_loop_start(input logic [4:0] op);
    return op == OP_START_LOOP || op == OP_START_INDEPENDENT_LOOP;
  endfunction
endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: instruction-memory read port and decoder issue handshake
//   master (sequencer): drives imem_rd_en/imem_addr and issue_valid/issue_instr
//   slave (memory + decoder): drives imem_rdata (1-cycle latency) and issue_ready
interface instruction_sequencer_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 18
);
  logic                   imem_rd_en;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   issue_valid;
  logic [INSTR_WIDTH-1:0] issue_instr;
  logic                   issue_ready;
  modport master (output imem_rd_en, imem_addr, issue_valid, issue_instr, input imem_rdata, issue_ready);
  modport slave  (input imem_rd_en, imem_addr, issue_valid, issue_instr, output imem_rdata, issue_ready);
endinterface

// File: rtl/instruction_sequencer_loop_stack.sv
// instruction_sequencer_loop_stack: LOOP_DEPTH-deep LIFO of loop entries
//   clear/push/pop/dec (priority in that order; push and pop never together)
//   stk_top: top entry (meaningless when empty), empty, full
module instruction_sequencer_loop_stack
  import instruction_sequencer_pkg::*;
#(
  parameter int LOOP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic        dec,
  input  loop_entry_t push_entry,
  output loop_entry_t stk_top,
  output logic        empty,
  output logic        full
);
  localparam int CW = $clog2(LOOP_DEPTH + 1);
  localparam int IW = LOOP_DEPTH > 1 ? $clog2(LOOP_DEPTH) : 1;
  loop_entry_t   ent_q [LOOP_DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] top_cnt;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;
  assign top_cnt  = cnt_q - CW'(1);
  assign top_idx  = top_cnt[IW-1:0];
  assign push_idx = cnt_q[IW-1:0];
  assign stk_top  = ent_q[top_idx];
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == CW'(LOOP_DEPTH);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int i = 0; i < LOOP_DEPTH; i++) ent_q[i] <= '0;
    end else if (clear) cnt_q <= '0;
    else if (push) begin
      ent_q[push_idx] <= push_entry;
      cnt_q <= cnt_q + CW'(1);
    end else if (pop) cnt_q <= cnt_q - CW'(1);
    else if (dec) ent_q[top_idx].remaining <= stk_top.remaining - 3'd1;
  end
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches raw instructions, runs loop opcodes on a hardware stack, issues the rest
//   clk, reset_n (async, active-low); start/start_pc launch a program; busy/done/error report status
//   bus (master): instruction memory read port and decoder valid/ready issue port
//   SEQ_PERF_COUNTERS_EN adds perf_issued/perf_stall saturating counters
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W,
  parameter int LOOP_DEPTH  = 4,
  parameter int INSTR_WIDTH = 18
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  output logic                busy,
  output logic                done,
  output logic                error,
`ifdef SEQ_PERF_COUNTERS_EN
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall,
`endif
  instruction_sequencer_if.master bus
);
  seq_state_t             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc;
  logic                   issue_valid_q, issue_valid_d;
  logic [INSTR_WIDTH-1:0] issue_instr_q, issue_instr_d;
  logic                   error_q, error_d, done_q, done_d, fail_q, fail_d;
  logic                   push, pop, dec, clear, fail, start_ok, empty, full, wrap;
  logic [4:0]             op;
  loop_entry_t            stk_top;
  assign op       = bus.imem_rdata[INSTR_WIDTH-1 -: 5];
  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign wrap     = &pc_q;
  // done_q/fail_q mark the cycle a program ended; a start there is dropped
  assign start_ok = state_q == IDLE && start && !done_q && !fail_q;
  instruction_sequencer_loop_stack #(.LOOP_DEPTH(LOOP_DEPTH)) u_stack (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .dec        (dec),
    .push_entry ('{body_pc: pc_inc, remaining: bus.imem_rdata[12:10]}),
    .stk_top    (stk_top),
    .empty      (empty),
    .full       (full)
  );
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    issue_valid_d = issue_valid_q;
    issue_instr_d = issue_instr_q;
    error_d       = error_q;
    done_d        = 1'b0;
    fail_d        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    dec           = 1'b0;
    clear         = 1'b0;
    fail          = 1'b0;
    case (state_q)
      IDLE: if (start_ok) begin
        pc_d    = start_pc;
        error_d = 1'b0;
        state_d = FETCH;
      end
      FETCH: state_d = EXEC;
      EXEC: if (is_loop_start(op)) begin
        fail    = full || wrap;
        push    = 1'b1;
        pc_d    = pc_inc;
        state_d = FETCH;
      end else if (op == OP_END_LOOP) begin
        fail    = empty || (stk_top.remaining == 3'd0 && wrap);
        dec     = stk_top.remaining != 3'd0;
        pop     = stk_top.remaining == 3'd0;
        pc_d    = dec ? stk_top.body_pc : pc_inc;
        state_d = FETCH;
      end else if (op == OP_HALT) begin
        fail    = !empty;
        done_d  = empty;
        state_d = IDLE;
      end else begin
        issue_valid_d = 1'b1;
        issue_instr_d = bus.imem_rdata;
        state_d       = ISSUE;
      end
      ISSUE: if (bus.issue_ready) begin
        fail          = wrap;
        issue_valid_d = 1'b0;
        pc_d          = pc_inc;
        state_d       = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (fail) begin
      error_d       = 1'b1;
      fail_d        = 1'b1;
      issue_valid_d = 1'b0;
      clear         = 1'b1;
      push          = 1'b0;
      pop           = 1'b0;
      dec           = 1'b0;
      state_d       = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      error_q       <= error_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end
  assign busy            = state_q != IDLE;
  assign done            = done_q;
  assign error           = error_q;
  assign bus.imem_rd_en  = state_q == FETCH;
  assign bus.imem_addr   = pc_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_instr = issue_instr_q;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] issued_q, stall_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else if (start_ok) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else if (state_q == ISSUE && bus.issue_ready) issued_q <= issued_q + {31'd0, ~&issued_q};
    else if (state_q == ISSUE) stall_q <= stall_q + {31'd0, ~&stall_q};
  end
  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed programs with an issue scoreboard against instruction_sequencer
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_pc = '0;
  logic       busy, done, error;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] perf_issued, perf_stall;
`endif
  instruction_sequencer_if #(.PC_WIDTH(10), .INSTR_WIDTH(18)) bus ();
  instruction_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .start_pc    (start_pc),
    .busy        (busy),
    .done        (done),
    .error       (error),
`ifdef SEQ_PERF_COUNTERS_EN
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .bus         (bus)
  );
  logic [17:0] mem [1024];
  logic [17:0] exp_q [$];
  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0, n_iss = 0, n_done = 0, a = 0;
  logic [17:0] v0;
  bit stable;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
  function automatic logic [17:0] ins(input logic [4:0] op, input logic [12:0] pl);
    return {op, pl};
  endfunction
  task automatic w(input logic [17:0] x);
    mem[a] = x;
    a++;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (bus.issue_valid && bus.issue_ready) begin
      n_iss++;
      e = exp_q.size() != 0 ? {14'd0, exp_q.pop_front()} : 32'hx;
      check("issue", {14'd0, bus.issue_instr}, e);
    end
    if (done) n_done++;
  endtask
  task automatic start_prog(input logic [9:0] spc);
    n_iss = 0;
    n_done = 0;
    @(posedge clk);
    #1 start = 1'b1;
    start_pc = spc;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
  endtask
  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) break;
    end
    check("program_ended", busy, 0);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 20 && !bus.issue_valid; i++) tick();
    check("issue_valid_seen", bus.issue_valid, 1);
  endtask
  task automatic results(input string tag, input int iss, input int dn, input logic err);
    check({tag, "_issues"}, n_iss, iss);
    check({tag, "_done"}, n_done, dn);
    check({tag, "_error"}, error, err);
    check({tag, "_leftover"}, exp_q.size(), 0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = ins(OP_HALT, 0);
    a = 'h000; w(ins(2, 'h0A5)); w(ins(4, 'h1C3)); w(ins(OP_HALT, 0));
    a = 'h010; w(ins(4, 'h0777)); w(ins(OP_HALT, 0));
    a = 'h020; w(ins(2, 'h011)); w(ins(3, 'h022)); w(ins(OP_HALT, 0));
    a = 'h040; w(ins(OP_START_LOOP, 'h0800)); w(ins(2, 'h033)); w(ins(OP_END_LOOP, 0)); w(ins(OP_HALT, 0));
    a = 'h060; w(ins(OP_START_LOOP, 'h0400)); w(ins(OP_START_INDEPENDENT_LOOP, 'h0800)); w(ins(3, 'h044));
    w(ins(OP_END_LOOP, 0)); w(ins(OP_END_LOOP, 0)); w(ins(OP_HALT, 0));
    a = 'h080; w(ins(OP_END_LOOP, 0));
    a = 'h0A0; repeat (5) w(ins(OP_START_LOOP, 'h0400)); w(ins(2, 'h055));
    a = 'h0C0; w(ins(OP_START_LOOP, 0)); w(ins(2, 'h066)); w(ins(OP_HALT, 0));
    a = 'h0E0; w(ins(2, 'h077)); w(ins(OP_HALT, 0));
    bus.issue_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rd_en", bus.imem_rd_en, 0);
    check("rst_valid", bus.issue_valid, 0);
    reset_n = 1'b1;
    exp_q.push_back(ins(2, 'h0A5));
    exp_q.push_back(ins(4, 'h1C3));
    start_prog('h000);
    wait_end(60);
    results("straight", 2, 1, 0);
    bus.issue_ready = 1'b0;
    exp_q.push_back(ins(2, 'h011));
    exp_q.push_back(ins(3, 'h022));
    start_prog('h020);
    wait_valid();
    v0 = bus.issue_instr;
    check("bp_first_instr", {14'd0, v0}, {14'd0, ins(2, 'h011)});
    stable = 1'b1;
    for (int j = 0; j < 4; j++) begin
      start = j == 1;
      start_pc = 'h080;
      tick();
      stable &= bus.issue_valid && bus.issue_instr == v0;
    end
    start = 1'b0;
    @(posedge clk);
    #1 bus.issue_ready = 1'b1;
    tick();
    stable &= bus.issue_valid && bus.issue_instr == v0;
    check("bp_stable", {31'd0, stable}, 1);
    wait_end(60);
    results("backpressure", 2, 1, 0);
`ifdef SEQ_PERF_COUNTERS_EN
    check("perf_stall", perf_stall, 5);
    check("perf_issued", perf_issued, 2);
`endif
    repeat (3) exp_q.push_back(ins(2, 'h033));
    start_prog('h040);
    wait_end(100);
    results("loop3", 3, 1, 0);
    repeat (6) exp_q.push_back(ins(3, 'h044));
    start_prog('h060);
    wait_end(200);
    results("nested", 6, 1, 0);
    start_prog('h080);
    wait_end(40);
    results("endloop_empty", 0, 0, 1);
    start_prog('h0A0);
    wait_end(60);
    results("overflow", 0, 0, 1);
    exp_q.push_back(ins(2, 'h066));
    start_prog('h0C0);
    wait_end(60);
    results("halt_in_loop", 1, 0, 1);
    bus.issue_ready = 1'b0;
    exp_q.push_back(ins(2, 'h077));
    start_prog('h0E0);
    wait_valid();
    #1 reset_n = 1'b0;
    #1;
    check("abort_valid", bus.issue_valid, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.issue_ready = 1'b1;
    exp_q.push_back(ins(4, 'h0777));
    start_prog('h010);
    wait_end(60);
    results("after_reset", 1, 1, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
